// File: rtl/sub_bytes_sched.sv
// sub_bytes_sched: time-multiplexes four shared S-box lanes
// between AES SubBytes (state) and SubWord (key) jobs.
module sub_bytes_sched #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         ky_req_valid,
  output logic         ky_req_ready,
  input  logic [31:0]  ky_req_data,
  output logic         ky_rsp_valid,
  input  logic         ky_rsp_ready,
  output logic [31:0]  ky_rsp_data,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_e;

  state_e              state_q;
  logic [1:0]          beat_q;
  logic                job_ky_q;
  logic                lg_ky_q;
  logic [95:0]         data_q;
  logic [31:0]         sbox_in_q;
  logic                st_rsp_valid_q;
  logic                ky_rsp_valid_q;
  logic [127:0]        st_rsp_data_q;
  logic [31:0]         ky_rsp_data_q;
  logic [SBOX_LAT-1:0] tag_v_q;
  logic [1:0]          tag_idx_q [SBOX_LAT];
  logic [3:0][31:0]    res_q;
  logic [3:0][31:0]    res_d;

  logic                gnt_st;
  logic                gnt_ky;
  logic                issue;
  logic                cap;
  logic [1:0]          cap_idx;
  logic [1:0]          last_idx;
  logic                cap_last;
  logic [31:0]         next_word;

  assign issue    = (state_q == ISSUE);
  assign cap      = tag_v_q[SBOX_LAT-1];
  assign cap_idx  = tag_idx_q[SBOX_LAT-1];
  assign last_idx = job_ky_q ? 2'd0 : 2'd3;
  assign cap_last = cap && (cap_idx == last_idx);

  assign st_req_ready = gnt_st;
  assign ky_req_ready = gnt_ky;
  assign st_rsp_valid = st_rsp_valid_q;
  assign ky_rsp_valid = ky_rsp_valid_q;
  assign st_rsp_data  = st_rsp_data_q;
  assign ky_rsp_data  = ky_rsp_data_q;
  assign sbox_in      = sbox_in_q;

  // Idle-only grant; a tie goes to whoever was not served last.
  always_comb begin
    gnt_st = 1'b0;
    gnt_ky = 1'b0;
    if (!rst && state_q == IDLE) begin
      unique case (1'b1)
        st_req_valid && !ky_req_valid: gnt_st = 1'b1;
        ky_req_valid && !st_req_valid: gnt_ky = 1'b1;
        st_req_valid && ky_req_valid: begin
          gnt_st = lg_ky_q;
          gnt_ky = !lg_ky_q;
        end
        default: ;
      endcase
    end
  end

  // Word following the current beat of a state job.
  always_comb begin
    next_word = '0;
    unique case (beat_q)
      2'd0:    next_word = data_q[95:64];
      2'd1:    next_word = data_q[63:32];
      2'd2:    next_word = data_q[31:0];
      default: next_word = '0;
    endcase
  end

  // Drop the returning lane word into the slot its tag names.
  always_comb begin
    res_d = res_q;
    if (cap) res_d[cap_idx] = sbox_out;
  end

  // Tag pipe mirrors the lane latency so results find their slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q <= '0;
    end else begin
      tag_v_q[0]   <= issue;
      tag_idx_q[0] <= beat_q;
      for (int i = 1; i < SBOX_LAT; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  // Result slot storage.
  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  // Job FSM with registered lane drive and responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_q         <= 2'd0;
      job_ky_q       <= 1'b0;
      lg_ky_q        <= 1'b1;
      data_q         <= '0;
      sbox_in_q      <= '0;
      st_rsp_valid_q <= 1'b0;
      ky_rsp_valid_q <= 1'b0;
      st_rsp_data_q  <= '0;
      ky_rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_st) begin
            data_q    <= st_req_data[95:0];
            sbox_in_q <= st_req_data[127:96];
            beat_q    <= 2'd0;
            job_ky_q  <= 1'b0;
            lg_ky_q   <= 1'b0;
            state_q   <= ISSUE;
          end else if (gnt_ky) begin
            sbox_in_q <= ky_req_data;
            beat_q    <= 2'd0;
            job_ky_q  <= 1'b1;
            lg_ky_q   <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (beat_q == last_idx) begin
            sbox_in_q <= '0;
            state_q   <= DRAIN;
          end else begin
            sbox_in_q <= next_word;
            beat_q    <= beat_q + 2'd1;
          end
        end
        DRAIN: begin
          if (cap_last) begin
            state_q <= RESP;
            if (job_ky_q) begin
              ky_rsp_valid_q <= 1'b1;
              ky_rsp_data_q  <= res_d[0];
            end else begin
              st_rsp_valid_q <= 1'b1;
              st_rsp_data_q  <= {res_d[0], res_d[1],
                                 res_d[2], res_d[3]};
            end
          end
        end
        RESP: begin
          if ((st_rsp_valid_q && st_rsp_ready) ||
              (ky_rsp_valid_q && ky_rsp_ready)) begin
            st_rsp_valid_q <= 1'b0;
            ky_rsp_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_sched.sv
// tb_sub_bytes_sched: two DUTs (lane latency 1 and 4) driven
// by table vectors, corner sequences and random jobs.
module tb_sub_bytes_sched;

  logic clk;
  logic rst;

  logic [1:0]        sv, kv, sr, kr;
  logic [1:0][127:0] sd;
  logic [1:0][31:0]  kd;
  logic [1:0]        sqr, kqr, srv, krv;
  logic [1:0][127:0] srd;
  logic [1:0][31:0]  krd;
  logic [1:0][31:0]  sbi, sbo;

  logic [31:0]      p0;
  logic [3:0][31:0] p1;
  logic [7:0]       sbt [256];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int           d;
    bit           ky;
    logic [127:0] din;
    logic [127:0] exp;
    int           lat;
    int           stall;
  } vec_t;

  vec_t tv [7];

  sub_bytes_sched #(.SBOX_LAT(1)) u0 (
    .clk(clk), .rst(rst),
    .st_req_valid(sv[0]), .st_req_ready(sqr[0]),
    .st_req_data(sd[0]),
    .st_rsp_valid(srv[0]), .st_rsp_ready(sr[0]),
    .st_rsp_data(srd[0]),
    .ky_req_valid(kv[0]), .ky_req_ready(kqr[0]),
    .ky_req_data(kd[0]),
    .ky_rsp_valid(krv[0]), .ky_rsp_ready(kr[0]),
    .ky_rsp_data(krd[0]),
    .sbox_in(sbi[0]), .sbox_out(sbo[0])
  );

  sub_bytes_sched #(.SBOX_LAT(4)) u1 (
    .clk(clk), .rst(rst),
    .st_req_valid(sv[1]), .st_req_ready(sqr[1]),
    .st_req_data(sd[1]),
    .st_rsp_valid(srv[1]), .st_rsp_ready(sr[1]),
    .st_rsp_data(srd[1]),
    .ky_req_valid(kv[1]), .ky_req_ready(kqr[1]),
    .ky_req_data(kd[1]),
    .ky_rsp_valid(krv[1]), .ky_rsp_ready(kr[1]),
    .ky_rsp_data(krd[1]),
    .sbox_in(sbi[1]), .sbox_out(sbo[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return r;
  endfunction

  // Reference S-box from the GF(2^8) inverse and affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
           {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbt[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] w);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = sub32(w[32*i +: 32]);
    return r;
  endfunction

  // External lanes: latency 1 for u0, latency 4 for u1.
  always @(posedge clk) begin
    p0    <= sub32(sbi[0]);
    p1[0] <= sub32(sbi[1]);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
    p1[3] <= p1[2];
  end

  assign sbo[0] = p0;
  assign sbo[1] = p1[3];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_v(input int d, input bit ky);
    int k = 0;
    while ((ky ? krv[d] : srv[d]) !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d rsp timeout", d),
        128'(ky ? krv[d] : srv[d]), 128'd1);
  endtask

  // One job: accept, beat check, latency, data, optional stall.
  task automatic do_job(input int d, input bit ky,
                        input logic [127:0] din,
                        input logic [127:0] exp,
                        input int lat, input int stall);
    int k;
    int nb;
    bit ok;
    logic [127:0] hold;
    nb = ky ? 1 : 4;
    if (stall == 0) begin
      sr[d] = 1'b1;
      kr[d] = 1'b1;
    end
    if (ky) begin
      kv[d] = 1'b1;
      kd[d] = din[31:0];
    end else begin
      sv[d] = 1'b1;
      sd[d] = din;
    end
    #1;
    k = 0;
    while ((ky ? kqr[d] : sqr[d]) !== 1'b1 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk($sformatf("d%0d accept", d), 128'(k < 100), 128'd1);
    if (k >= 100) begin
      sv[d] = 1'b0;
      kv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    sv[d] = 1'b0;
    kv[d] = 1'b0;
    sd[d] = ~sd[d];
    kd[d] = ~kd[d];
    k = 1;
    while (k < 40) begin
      if (k <= nb)
        chk($sformatf("d%0d sbox_in beat%0d", d, k - 1),
            128'(sbi[d]),
            ky ? 128'(din[31:0]) : 128'(din[127-32*(k-1) -: 32]));
      else if (k == nb + 1)
        chk($sformatf("d%0d sbox_in idle", d), 128'(sbi[d]), 128'd0);
      if ((ky ? krv[d] : srv[d]) === 1'b1) break;
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d latency", d), 128'(k), 128'(lat));
    hold = ky ? 128'(krd[d]) : srd[d];
    chk($sformatf("d%0d rsp_data", d), hold, exp);
    if (stall > 0) begin
      ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
        sv[d] = 1'b1;
        kv[d] = 1'b1;
        sd[d] = {$urandom, $urandom, $urandom, $urandom};
        kd[d] = $urandom;
        #1;
        if (sqr[d] !== 1'b0 || kqr[d] !== 1'b0) ok = 1'b0;
        @(negedge clk);
        if ((ky ? krv[d] : srv[d]) !== 1'b1) ok = 1'b0;
        if ((ky ? 128'(krd[d]) : srd[d]) !== hold) ok = 1'b0;
      end
      sv[d] = 1'b0;
      kv[d] = 1'b0;
      chk($sformatf("d%0d stall hold", d), 128'(ok), 128'd1);
      sr[d] = 1'b1;
      kr[d] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    sr[d] = 1'b0;
    kr[d] = 1'b0;
    chk($sformatf("d%0d rsp drop", d),
        128'(ky ? krv[d] : srv[d]), 128'd0);
  endtask

  initial begin
    logic [127:0] a;
    logic [31:0]  b;
    logic [127:0] din;
    logic [127:0] exp;
    bit           ky;
    int           st;
    bit           ok;

    for (int i = 0; i < 256; i++) sbt[i] = sbox_ref(8'(i));

    tv[0] = '{0, 1'b0, 128'h0, {16{8'h63}}, 6, 0};
    tv[1] = '{0, 1'b1, 128'h01020304, 128'h7c777bf2, 3, 0};
    tv[2] = '{0, 1'b0, 128'h00112233445566778899aabbccddeeff,
              128'h638293c31bfc33f5c4eeacea4bc12816, 6, 10};
    tv[3] = '{1, 1'b0, 128'h00112233445566778899aabbccddeeff,
              128'h638293c31bfc33f5c4eeacea4bc12816, 9, 0};
    tv[4] = '{1, 1'b1, 128'h0, 128'h63636363, 6, 2};
    tv[5] = '{1, 1'b1, 128'hffffffff, 128'h16161616, 6, 0};
    tv[6] = '{1, 1'b0, {16{8'hff}}, {16{8'h16}}, 9, 0};

    rst = 1'b1;
    sv = 2'b11;
    kv = 2'b11;
    sr = 2'b00;
    kr = 2'b00;
    sd = '0;
    kd = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("ready in reset", 128'({sqr, kqr}), 128'd0);
    chk("rsp valid reset", 128'({srv, krv}), 128'd0);
    chk("st data reset", srd[0] | srd[1], 128'd0);
    chk("ky data reset", 128'(krd[0] | krd[1]), 128'd0);
    chk("sbox_in reset", 128'(sbi[0] | sbi[1]), 128'd0);
    sv = 2'b00;
    kv = 2'b00;
    rst = 1'b0;
    @(negedge clk);

    a = 128'h3243f6a8885a308d313198a2e0370734;
    b = 32'h09cf4f3c;
    sv[0] = 1'b1;
    kv[0] = 1'b1;
    sd[0] = a;
    kd[0] = b;
    sr[0] = 1'b1;
    kr[0] = 1'b1;
    #1;
    chk("arb tie 1", 128'({sqr[0], kqr[0]}), 128'b10);
    @(posedge clk);
    @(negedge clk);
    wait_v(0, 1'b0);
    chk("arb st data", srd[0], sub128(a));
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("arb tie 2", 128'({sqr[0], kqr[0]}), 128'b01);
    @(posedge clk);
    @(negedge clk);
    wait_v(0, 1'b1);
    chk("arb ky data", 128'(krd[0]), 128'(sub32(b)));
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("arb tie 3", 128'({sqr[0], kqr[0]}), 128'b10);
    sv[0] = 1'b0;
    kv[0] = 1'b0;
    sr[0] = 1'b0;
    kr[0] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_job(tv[i].d, tv[i].ky, tv[i].din, tv[i].exp,
             tv[i].lat, tv[i].stall);

    din = {$urandom, $urandom, $urandom, $urandom};
    sv[0] = 1'b1;
    sd[0] = din;
    sr[0] = 1'b1;
    #1;
    chk("rst job accept", 128'(sqr[0]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    sv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready mid rst", 128'({sqr[0], kqr[0]}), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (srv[0] !== 1'b0 || srd[0] !== 128'd0) ok = 1'b0;
      if (sbi[0] !== 32'd0) ok = 1'b0;
      @(negedge clk);
    end
    chk("abandoned job silent", 128'(ok), 128'd1);
    sr[0] = 1'b0;
    b = 32'ha5c3e10f;
    do_job(0, 1'b1, 128'(b), 128'(sub32(b)), 3, 0);

    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 25; j++) begin
        ky = 1'($urandom_range(0, 1));
        din = {$urandom, $urandom, $urandom, $urandom};
        if (ky) din[127:32] = '0;
        exp = ky ? 128'(sub32(din[31:0])) : sub128(din);
        st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        do_job(d, ky, din, exp, (d == 1 ? 4 : 1) + (ky ? 2 : 5), st);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
